// File: rtl/mem_arbiter.sv
// Two-port SRAM bus arbiter: data port has priority over instruction fetch.
// Single bus master cycle at a time, with a wait-count timeout and fetch discard on flush.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic [31:0] i_data_o,
  output logic        i_ack_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ack_o,
  input  logic        flush_i,
  output logic        sram_ce_o,
  output logic        sram_we_o,
  output logic [3:0]  sram_sel_o,
  output logic [31:0] sram_addr_o,
  output logic [31:0] sram_data_o,
  input  logic [31:0] sram_data_i,
  input  logic        sram_ack_i,
  output logic        err_o,
  output logic        stallreq_if_o,
  output logic        stallreq_mem_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [7:0]  count_reg, count_next;
  logic        discard_reg, discard_next;
  logic        ce_reg, ce_next;
  logic        we_reg, we_next;
  logic [3:0]  sel_reg, sel_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        i_ack_reg, i_ack_next;
  logic [31:0] i_data_reg, i_data_next;
  logic        d_ack_reg, d_ack_next;
  logic [31:0] d_rdata_reg, d_rdata_next;
  logic        err_reg, err_next;

  logic in_idle;
  logic in_bus;
  logic grant_d;
  logic grant_i;
  logic term_ack;
  logic term_timeout;
  logic term;
  logic fetch_dropped;

  // A port is not re-granted in the cycle its own ack is showing.
  assign in_idle       = (state_reg == IDLE);
  assign in_bus        = (state_reg == BUS_I) || (state_reg == BUS_D);
  assign grant_d       = in_idle && d_req_i && !d_ack_reg;
  assign grant_i       = in_idle && i_req_i && !i_ack_reg && !grant_d;
  assign term_ack      = in_bus && sram_ack_i;
  assign term_timeout  = in_bus && !sram_ack_i && (count_reg == LAST_WAIT);
  assign term          = term_ack || term_timeout;
  assign fetch_dropped = (state_reg == BUS_I) && (discard_reg || flush_i);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      count_reg   <= 8'd0;
      discard_reg <= 1'b0;
      ce_reg      <= 1'b0;
      we_reg      <= 1'b0;
      sel_reg     <= 4'd0;
      addr_reg    <= 32'd0;
      wdata_reg   <= 32'd0;
      i_ack_reg   <= 1'b0;
      i_data_reg  <= 32'd0;
      d_ack_reg   <= 1'b0;
      d_rdata_reg <= 32'd0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      discard_reg <= discard_next;
      ce_reg      <= ce_next;
      we_reg      <= we_next;
      sel_reg     <= sel_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      i_ack_reg   <= i_ack_next;
      i_data_reg  <= i_data_next;
      d_ack_reg   <= d_ack_next;
      d_rdata_reg <= d_rdata_next;
      err_reg     <= err_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_d) begin
          state_next = BUS_D;
        end else if (grant_i) begin
          state_next = BUS_I;
        end
      end
      BUS_I, BUS_D: begin
        if (term) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: bus fields hold between grant and termination; acks, data and err are pulses
  always_comb begin
    count_next   = count_reg;
    discard_next = discard_reg;
    ce_next      = ce_reg;
    we_next      = we_reg;
    sel_next     = sel_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    i_ack_next   = 1'b0;
    i_data_next  = 32'd0;
    d_ack_next   = 1'b0;
    d_rdata_next = 32'd0;
    err_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_d) begin
          ce_next      = 1'b1;
          we_next      = d_we_i;
          sel_next     = d_sel_i;
          addr_next    = d_addr_i;
          wdata_next   = d_wdata_i;
          count_next   = 8'd0;
          discard_next = 1'b0;
        end else if (grant_i) begin
          ce_next      = 1'b1;
          we_next      = 1'b0;
          sel_next     = 4'hF;
          addr_next    = i_addr_i;
          wdata_next   = 32'd0;
          count_next   = 8'd0;
          discard_next = 1'b0;
        end
      end
      BUS_I, BUS_D: begin
        if (term) begin
          ce_next      = 1'b0;
          we_next      = 1'b0;
          sel_next     = 4'd0;
          addr_next    = 32'd0;
          wdata_next   = 32'd0;
          count_next   = 8'd0;
          discard_next = 1'b0;
          err_next     = term_timeout;
          if (state_reg == BUS_D) begin
            d_ack_next   = 1'b1;
            d_rdata_next = term_ack ? sram_data_i : 32'd0;
          end else if (!fetch_dropped) begin
            i_ack_next  = 1'b1;
            i_data_next = term_ack ? sram_data_i : 32'd0;
          end
        end else begin
          count_next   = count_reg + 8'd1;
          discard_next = fetch_dropped;
        end
      end
      default: begin
        ce_next = 1'b0;
      end
    endcase
  end

  assign sram_ce_o      = ce_reg;
  assign sram_we_o      = we_reg;
  assign sram_sel_o     = sel_reg;
  assign sram_addr_o    = addr_reg;
  assign sram_data_o    = wdata_reg;
  assign i_ack_o        = i_ack_reg;
  assign i_data_o       = i_data_reg;
  assign d_ack_o        = d_ack_reg;
  assign d_rdata_o      = d_rdata_reg;
  assign err_o          = err_reg;
  assign stallreq_if_o  = i_req_i & ~i_ack_reg;
  assign stallreq_mem_o = d_req_i & ~d_ack_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal checks, then random traffic
// compared every cycle against a transaction-level model.
module tb_mem_arbiter;

  localparam int TMO = 4;

  logic        clk;
  logic        rst;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic [31:0] i_data_o;
  logic        i_ack_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [3:0]  d_sel_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [31:0] d_rdata_o;
  logic        d_ack_o;
  logic        flush_i;
  logic        sram_ce_o;
  logic        sram_we_o;
  logic [3:0]  sram_sel_o;
  logic [31:0] sram_addr_o;
  logic [31:0] sram_data_o;
  logic [31:0] sram_data_i;
  logic        sram_ack_i;
  logic        err_o;
  logic        stallreq_if_o;
  logic        stallreq_mem_o;

  int n_cmp = 0;
  int n_err = 0;

  // Model: one outstanding transaction described by who owns the bus and how long it has waited.
  bit          m_busy;
  bit          m_is_d;
  bit          m_discard;
  int          m_age;
  logic        e_ce;
  logic        e_we;
  logic [3:0]  e_sel;
  logic [31:0] e_addr;
  logic [31:0] e_wdata;
  logic        e_iack;
  logic [31:0] e_idata;
  logic        e_dack;
  logic [31:0] e_ddata;
  logic        e_err;

  mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_i       (i_req_i),
    .i_addr_i      (i_addr_i),
    .i_data_o      (i_data_o),
    .i_ack_o       (i_ack_o),
    .d_req_i       (d_req_i),
    .d_we_i        (d_we_i),
    .d_sel_i       (d_sel_i),
    .d_addr_i      (d_addr_i),
    .d_wdata_i     (d_wdata_i),
    .d_rdata_o     (d_rdata_o),
    .d_ack_o       (d_ack_o),
    .flush_i       (flush_i),
    .sram_ce_o     (sram_ce_o),
    .sram_we_o     (sram_we_o),
    .sram_sel_o    (sram_sel_o),
    .sram_addr_o   (sram_addr_o),
    .sram_data_o   (sram_data_o),
    .sram_data_i   (sram_data_i),
    .sram_ack_i    (sram_ack_i),
    .err_o         (err_o),
    .stallreq_if_o (stallreq_if_o),
    .stallreq_mem_o(stallreq_mem_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Literal expectation applied to both the DUT and the model.
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] mdl,
                     input logic [31:0] exp);
    chk(name, act, exp);
    chk({name, "_model"}, mdl, exp);
  endtask

  task automatic model_reset();
    m_busy = 0; m_is_d = 0; m_discard = 0; m_age = 0;
    e_ce = 0; e_we = 0; e_sel = 0; e_addr = 0; e_wdata = 0;
    e_iack = 0; e_idata = 0; e_dack = 0; e_ddata = 0; e_err = 0;
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_step();
    bit gd;
    bit gi;
    logic [31:0] rd;
    if (!rst) begin
      model_reset();
      return;
    end
    gd = d_req_i && !e_dack;
    gi = i_req_i && !e_iack && !gd;
    e_iack = 0; e_idata = 0; e_dack = 0; e_ddata = 0; e_err = 0;
    if (!m_busy) begin
      if (gd || gi) begin
        m_busy = 1; m_is_d = gd; m_discard = 0; m_age = 0; e_ce = 1;
        e_we    = gd ? d_we_i : 1'b0;
        e_sel   = gd ? d_sel_i : 4'hF;
        e_addr  = gd ? d_addr_i : i_addr_i;
        e_wdata = gd ? d_wdata_i : 32'd0;
      end
    end else begin
      if (!m_is_d && flush_i) m_discard = 1;
      m_age++;
      if (sram_ack_i || m_age == TMO) begin
        rd = sram_ack_i ? sram_data_i : 32'd0;
        e_err = !sram_ack_i;
        if (m_is_d) begin
          e_dack = 1; e_ddata = rd;
        end else if (!m_discard) begin
          e_iack = 1; e_idata = rd;
        end
        $display("txn %s addr=%h data=%h err=%0d dropped=%0d", m_is_d ? "D" : "I",
                 e_addr, rd, e_err, !m_is_d && m_discard);
        m_busy = 0; e_ce = 0; e_we = 0; e_sel = 0; e_addr = 0; e_wdata = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("sram_ce",   32'(sram_ce_o),   32'(e_ce));
    chk("sram_we",   32'(sram_we_o),   32'(e_we));
    chk("sram_sel",  32'(sram_sel_o),  32'(e_sel));
    chk("sram_addr", sram_addr_o,      e_addr);
    chk("sram_data", sram_data_o,      e_wdata);
    chk("i_ack",     32'(i_ack_o),     32'(e_iack));
    chk("i_data",    i_data_o,         e_idata);
    chk("d_ack",     32'(d_ack_o),     32'(e_dack));
    chk("d_rdata",   d_rdata_o,        e_ddata);
    chk("err",       32'(err_o),       32'(e_err));
    chk("stall_if",  32'(stallreq_if_o),  32'(i_req_i & ~e_iack));
    chk("stall_mem", 32'(stallreq_mem_o), 32'(d_req_i & ~e_dack));
  endtask

  // Compare at the falling edge, advance the model, return 1 time unit past the next rising edge.
  task automatic tick();
    @(negedge clk);
    compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    i_req_i = 0; i_addr_i = 0; d_req_i = 0; d_we_i = 0; d_sel_i = 0;
    d_addr_i = 0; d_wdata_i = 0; flush_i = 0; sram_data_i = 0; sram_ack_i = 0;
  endtask

  initial begin
    rst = 1'b1;
    quiet_inputs();
    model_reset();
    #2 rst = 1'b0;
    #1;
    lit("reset_ce",   32'(sram_ce_o), 32'(e_ce),   32'd0);
    lit("reset_dack", 32'(d_ack_o),   32'(e_dack), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Single fetch, ack on the first bus cycle
    i_req_i = 1; i_addr_i = 32'h0000_0010;
    tick();
    lit("f_ce",   32'(sram_ce_o),  32'(e_ce),  32'd1);
    lit("f_addr", sram_addr_o,     e_addr,     32'h10);
    lit("f_sel",  32'(sram_sel_o), 32'(e_sel), 32'hF);
    sram_ack_i = 1; sram_data_i = 32'h3C01_0001;
    tick();
    lit("f_ack",  32'(i_ack_o), 32'(e_iack), 32'd1);
    lit("f_data", i_data_o,     e_idata,     32'h3C01_0001);
    lit("f_ce_off", 32'(sram_ce_o), 32'(e_ce), 32'd0);
    quiet_inputs();
    tick();
    lit("f_data_after", i_data_o, e_idata, 32'd0);

    // Contention: data wins, fetch follows in the data ack cycle
    i_req_i = 1; i_addr_i = 32'h20; d_req_i = 1; d_we_i = 1;
    d_addr_i = 32'h100; d_wdata_i = 32'hDEAD_BEEF; d_sel_i = 4'b0011;
    tick();
    lit("c_we",    32'(sram_we_o),  32'(e_we),  32'd1);
    lit("c_addr",  sram_addr_o,     e_addr,     32'h100);
    lit("c_wdata", sram_data_o,     e_wdata,    32'hDEAD_BEEF);
    lit("c_sel",   32'(sram_sel_o), 32'(e_sel), 32'h3);
    sram_ack_i = 1; sram_data_i = 32'h55;
    tick();
    lit("c_dack",     32'(d_ack_o),       32'(e_dack), 32'd1);
    lit("c_stall_if", 32'(stallreq_if_o), 32'(i_req_i & ~e_iack), 32'd1);
    d_req_i = 0; sram_ack_i = 0;
    tick();
    lit("c_i_addr", sram_addr_o, e_addr, 32'h20);
    lit("c_i_we",   32'(sram_we_o), 32'(e_we), 32'd0);
    sram_ack_i = 1; sram_data_i = 32'h77;
    tick();
    lit("c_iack",     32'(i_ack_o),       32'(e_iack), 32'd1);
    lit("c_stall_if_done", 32'(stallreq_if_o), 32'(i_req_i & ~e_iack), 32'd0);
    quiet_inputs();
    tick();

    // Timeout on a data read with no bus ack
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h300; d_sel_i = 4'hF;
    tick();
    d_req_i = 0; sram_data_i = 32'hFFFF_FFFF;
    tick(); tick(); tick();
    lit("t_ce_wait", 32'(sram_ce_o), 32'(e_ce), 32'd1);
    tick();
    lit("t_dack",  32'(d_ack_o), 32'(e_dack), 32'd1);
    lit("t_err",   32'(err_o),   32'(e_err),  32'd1);
    lit("t_rdata", d_rdata_o,    e_ddata,     32'd0);
    lit("t_ce",    32'(sram_ce_o), 32'(e_ce), 32'd0);
    tick();
    lit("t_err_off", 32'(err_o), 32'(e_err), 32'd0);
    quiet_inputs();

    // Flush during a fetch: result dropped, next IDLE cycle regrants
    i_req_i = 1; i_addr_i = 32'h40;
    tick();
    flush_i = 1;
    tick();
    flush_i = 0; sram_ack_i = 1; sram_data_i = 32'h1234_5678;
    tick();
    lit("fl_iack", 32'(i_ack_o), 32'(e_iack), 32'd0);
    lit("fl_data", i_data_o,     e_idata,     32'd0);
    sram_ack_i = 0;
    tick();
    lit("fl_regrant", 32'(sram_ce_o), 32'(e_ce), 32'd1);
    sram_ack_i = 1; sram_data_i = 32'hA5A5;
    tick();
    lit("fl_iack2", 32'(i_ack_o), 32'(e_iack), 32'd1);
    quiet_inputs();
    tick();

    // Asynchronous reset in the middle of a data write
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h200; d_wdata_i = 32'h1; d_sel_i = 4'hF;
    tick();
    #2 rst = 1'b0;
    model_reset();
    #1;
    lit("r_ce",   32'(sram_ce_o), 32'(e_ce),   32'd0);
    lit("r_dack", 32'(d_ack_o),   32'(e_dack), 32'd0);
    lit("r_err",  32'(err_o),     32'(e_err),  32'd0);
    tick();
    rst = 1'b1;
    #1;
    lit("r_no_early_grant", 32'(sram_ce_o), 32'(e_ce), 32'd0);
    tick();
    lit("r_grant", 32'(sram_ce_o), 32'(e_ce), 32'd1);
    sram_ack_i = 1; sram_data_i = 32'h99;
    tick();
    lit("r_dack2", 32'(d_ack_o), 32'(e_dack), 32'd1);
    quiet_inputs();
    tick();

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b0;
        model_reset();
      end else begin
        rst = 1'b1;
      end
      i_req_i     = ($urandom_range(0, 2) != 0);
      i_addr_i    = $urandom;
      d_req_i     = ($urandom_range(0, 2) == 0);
      d_we_i      = 1'($urandom);
      d_sel_i     = 4'($urandom);
      d_addr_i    = $urandom;
      d_wdata_i   = $urandom;
      flush_i     = ($urandom_range(0, 9) == 0);
      sram_data_i = $urandom;
      sram_ack_i  = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the bus cycles to wait for sram_ack_i before forced termination (range 2..255).
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req_i  in  1  instruction-fetch request (from fetch stage).
- i_addr_i  in  32  fetch byte address.
- i_data_o  out  32  fetched instruction, valid while i_ack_o=1.
- i_ack_o  out  1  one-cycle fetch completion pulse.
- d_req_i  in  1  data request (from MEM stage).
- d_we_i  in  1  1 = write, 0 = read.
- d_sel_i  in  4  byte lane enables.
- d_addr_i  in  32  data byte address.
- d_wdata_i  in  32  write data.
- d_rdata_o  out  32  read data, valid while d_ack_o=1.
- d_ack_o  out  1  one-cycle data completion pulse.
- flush_i  in  1  pipeline flush; discards the fetch result.
- sram_ce_o  out  1  shared bus cycle active.
- sram_we_o  out  1  bus write strobe.
- sram_sel_o  out  4  bus byte lanes.
- sram_addr_o  out  32  bus address.
- sram_data_o  out  32  bus write data.
- sram_data_i  in  32  bus read data.
- sram_ack_i  in  1  bus completion, sampled only while sram_ce_o=1.
- err_o  out  1  one-cycle pulse on timeout termination.
- stallreq_if_o  out  1  = i_req_i & ~i_ack_o (combinational).
- stallreq_mem_o  out  1  = d_req_i & ~d_ack_o (combinational).

Function
REQ-003 SHALL implement an FSM with states IDLE, BUS_I and BUS_D.
REQ-004 In IDLE, d_req_i SHALL have priority: if d_req_i=1, go to BUS_D; else if i_req_i=1, go to BUS_I; else stay in IDLE.
REQ-005 In IDLE, a request from a port whose ack output is 1 in that cycle SHALL be ignored; no re-grant on the ack cycle.
REQ-006 On the grant edge, the arbiter SHALL register the granted port's fields onto sram_* and set sram_ce_o=1.
- Fetch grant: sram_we_o=0, sram_sel_o=4'hF, sram_data_o=0.
- Data grant: d_we_i, d_sel_i, d_addr_i and d_wdata_i.
REQ-007 The bus outputs SHALL remain stable until termination, regardless of changes on the request inputs.
REQ-008 In BUS_x with sram_ack_i=1, on the next edge the arbiter SHALL:
- clear sram_ce_o and all other sram_* outputs to 0;
- capture sram_data_i into the granted port's data output;
- pulse that port's ack for one cycle;
- return to IDLE.
REQ-009 Minimum latency SHALL be 2 cycles: request sampled at edge N, sram_ce_o=1 after N, ack_i high the same cycle, port ack high after edge N+1.
REQ-010 An 8-bit wait counter SHALL clear on grant and increment each BUS_x cycle without ack. When it reaches TIMEOUT-1 without ack, the transaction SHALL terminate as in REQ-008, with data output 0 and err_o pulsed together with the port ack.
REQ-011 If flush_i=1 in any cycle of BUS_I, a discard flag SHALL be set. The bus cycle SHALL still complete normally, but i_ack_o SHALL be suppressed and i_data_o held at 0.
REQ-012 flush_i SHALL NOT affect BUS_D or IDLE.
REQ-013 i_data_o and d_rdata_o SHALL be 0 in every cycle their ack is 0.
REQ-014 At most one of i_ack_o and d_ack_o SHALL be 1 in any cycle.
REQ-015 sram_ack_i SHALL be ignored while sram_ce_o=0.
REQ-016 A new grant SHALL never occur in the same cycle as a termination; there is at least one IDLE cycle between bus transactions.

Reset
REQ-017 While rst=0, asynchronously and including mid-transaction, the block SHALL enter IDLE, and all outputs, the counter and the discard flag SHALL be 0.
- stallreq_* outputs follow their combinational equations.
REQ-018 After rst rises, the first grant SHALL occur no earlier than the first rising clk edge.

Verification
REQ-019 Read fetch: i_req_i=1, i_addr_i=0x00000010, ack_i after 1 bus cycle with data 0x3C010001 -> sram_addr_o=0x10, sram_sel_o=F; i_ack_o pulses with i_data_o=0x3C010001 two cycles after request.
REQ-020 Contention: i_req_i and d_req_i both rise in the same cycle, d_we_i=1, d_addr_i=0x100, d_wdata_i=0xDEADBEEF, d_sel_i=4'b0011 -> data served first with sram_we_o=1 and those values; fetch granted in the IDLE cycle after d_ack_o; stallreq_if_o stays 1 until i_ack_o.
REQ-021 Timeout: TIMEOUT=4, sram_ack_i held 0 on a data read -> termination on the 4th bus cycle; d_ack_o=1, err_o=1, d_rdata_o=0; sram_ce_o=0 afterward.
REQ-022 Flush: flush_i pulsed during BUS_I, ack_i data 0x12345678 -> no i_ack_o pulse; i_data_o stays 0; the next IDLE cycle can grant.
REQ-023 Reset mid-operation: rst=0 asserted during BUS_D before ack -> sram_ce_o, d_ack_o and err_o become 0 immediately; after release, a new request is served normally with 2-cycle minimum latency.
